// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter sharing one 16-bit io slave between
// NUM_MASTERS requesters. Each transfer runs a req/gnt/ack handshake, strobes
// the slave for exactly one cycle and returns read data on m_din_o.
// FSM: IDLE -> ACCESS -> (WAIT, reads with RD_LATENCY>0) -> ACK -> IDLE.
// Optional feature: define IO_ARB_LOCK_EN to add the m_lock_i port, which lets
// a master keep the bus across consecutive transfers (atomic read-modify-write).
module io_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    input  logic [NUM_MASTERS-1:0]    m_wr_i,
    input  logic [16*NUM_MASTERS-1:0] m_addr_i,
    input  logic [16*NUM_MASTERS-1:0] m_dout_i,
`ifdef IO_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]    m_lock_i,
`endif
    output logic [NUM_MASTERS-1:0]    m_gnt_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [15:0]               m_din_o,
    output logic                      s_rd_o,
    output logic                      s_wr_o,
    output logic [15:0]               s_addr_o,
    output logic [15:0]               s_dout_o,
    input  logic [15:0]               s_din_i,
    output logic                      busy_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // WAIT spans RD_LATENCY cycles after the strobe; counter loads latency-1
    localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       rr_q;      // first index to consider in next arbitration
    logic [IDX_W-1:0]       win_q;     // master owning the current transfer
    logic [1:0]             cnt_q;     // remaining WAIT cycles
    logic [NUM_MASTERS-1:0] cand_d;    // requests eligible for arbitration
    logic [IDX_W-1:0]       win_d;
    logic                   any_d;
    logic [IDX_W-1:0]       rr_d;

`ifdef IO_ARB_LOCK_EN
    logic                   lock_vld_q;
    logic [IDX_W-1:0]       lock_own_q;
    logic                   lock_hold_d;

    // Lock owner monopolises arbitration while it keeps both lock and req high
    always_comb begin
        lock_hold_d = lock_vld_q && m_lock_i[lock_own_q] && m_req_i[lock_own_q];
        cand_d      = m_req_i;
        if (lock_hold_d) begin
            cand_d             = '0;
            cand_d[lock_own_q] = 1'b1;
        end
    end
`else
    assign cand_d = m_req_i;
`endif

    // Winner: first eligible request at or after the rr pointer, wrapping
    always_comb begin
        int idx;
        idx   = 0;
        any_d = 1'b0;
        win_d = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!any_d && cand_d[IDX_W'(idx)]) begin
                any_d = 1'b1;
                win_d = IDX_W'(idx);
            end
        end
    end

    // Pointer moves one past the master just served
    assign rr_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;

    // Transfer FSM; every output is a register so the slave sees clean strobes
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            m_gnt_o    <= '0;
            m_ack_o    <= '0;
            m_din_o    <= '0;
            s_rd_o     <= 1'b0;
            s_wr_o     <= 1'b0;
            s_addr_o   <= '0;
            s_dout_o   <= '0;
            busy_o     <= 1'b0;
`ifdef IO_ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef IO_ARB_LOCK_EN
                    if (lock_vld_q && !lock_hold_d) lock_vld_q <= 1'b0;
`endif
                    if (any_d) begin
                        state_q  <= ACCESS;
                        busy_o   <= 1'b1;
                        win_q    <= win_d;
                        m_gnt_o  <= NUM_MASTERS'(1) << win_d;
                        s_addr_o <= m_addr_i[{win_d, 4'h0} +: 16];
                        s_dout_o <= m_dout_i[{win_d, 4'h0} +: 16];
                        s_wr_o   <= m_wr_i[win_d];
                        s_rd_o   <= ~m_wr_i[win_d];
                    end
                end
                ACCESS: begin
                    s_rd_o <= 1'b0;
                    s_wr_o <= 1'b0;
                    if (s_wr_o) begin
                        state_q <= ACK;
                        m_ack_o <= m_gnt_o;
                    end else if (RD_LATENCY == 0) begin
                        m_din_o <= s_din_i;
                        state_q <= ACK;
                        m_ack_o <= m_gnt_o;
                    end else begin
                        cnt_q   <= WAIT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        m_din_o <= s_din_i;
                        state_q <= ACK;
                        m_ack_o <= m_gnt_o;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ACK: begin
                    m_ack_o <= '0;
                    m_gnt_o <= '0;
                    busy_o  <= 1'b0;
                    rr_q    <= rr_d;
                    state_q <= IDLE;
`ifdef IO_ARB_LOCK_EN
                    lock_vld_q <= m_lock_i[win_q];
                    lock_own_q <= win_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
